// File: rtl/jtcps1_bank_arb.sv
// jtcps1_bank_arb
//   Shares one single-command SDRAM controller between the four CPS1 bank
//   request ports and slips auto-refresh commands in while refresh_en is high.
//   One command is in flight at a time. Banks are served round-robin.
//   Refresh tokens accumulate during blanking. Once the token count reaches
//   RFSH_MAX, refresh takes priority over bank traffic.
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   refresh_en          refresh window (vertical blank)
//   ba_rd, ba0_wr       per-bank read requests, bank 0 write request (held until ack)
//   ba0..3_addr         per-bank word address
//   ba0_din, ba0_din_m  bank 0 write data and byte mask
//   ba_ack              one-cycle pulse when the controller accepts a bank command
//   ba_rdy              one-cycle pulse, aligned with sdram_done, for the served bank
//   sdram_*             command interface to the SDRAM engine
//   busy                arbiter not idle
module jtcps1_bank_arb #(
  parameter int unsigned AW          = 22,
  parameter int unsigned RFSH_PERIOD = 750,
  parameter int unsigned RFSH_MAX    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          refresh_en,
  input  logic [3:0]    ba_rd,
  input  logic          ba0_wr,
  input  logic [AW-1:0] ba0_addr,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic [15:0]   ba0_din,
  input  logic [1:0]    ba0_din_m,
  output logic [3:0]    ba_ack,
  output logic [3:0]    ba_rdy,
  output logic          sdram_req,
  output logic [1:0]    sdram_ba,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_wr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_mask,
  output logic          sdram_rfsh,
  input  logic          sdram_gnt,
  input  logic          sdram_done,
  output logic          busy
);

  localparam int unsigned TW = $clog2(RFSH_MAX + 1);
  localparam int unsigned CW = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;
  localparam logic [TW-1:0] TOK_MAX = TW'(RFSH_MAX);
  localparam logic [CW-1:0] CNT_RLD = CW'(RFSH_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, CMD, WAIT, RFSH, RWAIT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    rr_q, rr_d;
  logic [1:0]    bank_q, bank_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [15:0]   din_q, din_d;
  logic [1:0]    mask_q, mask_d;
  logic [3:0]    ack_q, ack_d;
  logic [TW-1:0] tok_q, tok_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]    req;
  logic [1:0]    win, cand;
  logic          any;
  logic [AW-1:0] win_addr;
  logic          tok_inc, tok_use;

  assign req = ba_rd | {3'b000, ba0_wr};

  // Round-robin search starting at rr_q; the 2-bit sum wraps modulo 4.
  always_comb begin
    win  = rr_q;
    cand = rr_q;
    any  = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = rr_q + 2'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
  end

  always_comb begin
    unique case (win)
      2'd0:    win_addr = ba0_addr;
      2'd1:    win_addr = ba1_addr;
      2'd2:    win_addr = ba2_addr;
      default: win_addr = ba3_addr;
    endcase
  end

  // Refresh counter and token count. A token earned and a token spent in the
  // same cycle cancel out. The count saturates at RFSH_MAX and does not go below 0.
  always_comb begin
    cnt_d   = cnt_q;
    tok_inc = 1'b0;
    if (refresh_en) begin
      if (cnt_q == '0) begin
        cnt_d   = CNT_RLD;
        tok_inc = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
    tok_use = (state_q == RFSH) && sdram_gnt;
    tok_d   = tok_q;
    if (!refresh_en) begin
      tok_d = '0;
    end else if (tok_inc && !tok_use && tok_q != TOK_MAX) begin
      tok_d = tok_q + TW'(1);
    end else if (tok_use && !tok_inc && tok_q != '0) begin
      tok_d = tok_q - TW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    din_d   = din_q;
    mask_d  = mask_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (tok_q == TOK_MAX) begin
          state_d = RFSH;
          wr_d    = 1'b0;
        end else if (any) begin
          state_d = CMD;
          rr_d    = win + 2'd1;
          bank_d  = win;
          addr_d  = win_addr;
          wr_d    = (win == 2'd0) && ba0_wr;
          din_d   = ba0_din;
          mask_d  = ba0_din_m;
        end else if (tok_q != '0 && refresh_en) begin
          state_d = RFSH;
          wr_d    = 1'b0;
        end
      end
      CMD: begin
        if (sdram_gnt) begin
          state_d = WAIT;
          ack_d   = 4'b0001 << bank_q;
        end
      end
      WAIT:  if (sdram_done) state_d = IDLE;
      RFSH:  if (sdram_gnt)  state_d = RWAIT;
      RWAIT: if (sdram_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      bank_q  <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      mask_q  <= '0;
      ack_q   <= '0;
      tok_q   <= '0;
      cnt_q   <= CNT_RLD;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      mask_q  <= mask_d;
      ack_q   <= ack_d;
      tok_q   <= tok_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sdram_req  = (state_q == CMD);
  assign sdram_rfsh = (state_q == RFSH);
  assign busy       = (state_q != IDLE);
  assign sdram_ba   = bank_q;
  assign sdram_addr = addr_q;
  assign sdram_wr   = wr_q;
  assign sdram_din  = din_q;
  assign sdram_mask = mask_q;
  assign ba_ack     = ack_q;
  // ba_rdy is combinational so that it lines up with the controller's read data.
  assign ba_rdy     = (state_q == WAIT && sdram_done) ? (4'b0001 << bank_q) : 4'b0000;

endmodule
